rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, 15, maximum consecutive cycles one grant is held before forced release (legal range 1..15).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: req  input  8  request lines; req[i] high = requester i wants the shared resource.
REQ-005 Port: done  input  1  current grantee releases the resource; sampled only in GRANT.
REQ-006 Port: grant  output  8  one-hot grant; bit i high = requester i owns the resource.
REQ-007 Port: grant_idx  output  3  binary index of current or most recent grantee.
REQ-008 Port: grant_valid  output  1  high while any grant is active.
REQ-009 Port: expired  output  1  single-cycle pulse after a forced (timeout) release.
REQ-010 The design SHALL use one clock and a synchronous, active-high reset; all outputs SHALL be registered or decoded only from registered state.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and GRANT (grant active).
REQ-012 In IDLE with req != 0 at edge N, the FSM SHALL enter GRANT, and grant_valid=1 SHALL be visible in cycle N+1 (one-cycle latency).
REQ-013 In IDLE with req == 0, the FSM SHALL stay in IDLE; grant=0, grant_valid=0.
REQ-014 The winner SHALL be the first asserted req bit found searching upward from rotating pointer ptr (3 bits), wrapping 7 -> 0.
REQ-015 On every release, ptr SHALL become (grant_idx + 1) mod 8; ptr SHALL be unchanged while in IDLE with no requests.
REQ-016 grant SHALL equal the 3-to-8 one-hot decode of grant_idx when grant_valid=1, and SHALL be 8'h00 otherwise.
REQ-017 grant_idx SHALL hold its last value in IDLE.
REQ-018 Hold counter SHALL load 1 on GRANT entry and increment each GRANT cycle; width 4 bits, no wrap.
REQ-019 GRANT SHALL exit to IDLE at the edge where any of the following holds: done=1; req[grant_idx]=0; hold counter == MAX_HOLD.
REQ-020 A grant SHALL therefore last at most MAX_HOLD cycles of grant_valid=1.
REQ-021 Every release SHALL be followed by at least one IDLE cycle (grant_valid=0) before the next grant; back-to-back grants SHALL NOT occur.
REQ-022 expired SHALL pulse high for exactly the IDLE cycle following a release caused only by timeout.
REQ-023 If done=1 or req[grant_idx]=0 coincides with the timeout, the release SHALL count as normal and expired SHALL stay 0.
REQ-024 In GRANT, changes on non-granted req bits SHALL be ignored.
REQ-025 done asserted in IDLE SHALL have no effect.

Reset
REQ-026 With rst=1 at an edge, the next cycle SHALL show: state IDLE, ptr=0, hold counter=0, grant=8'h00, grant_idx=0, grant_valid=0, expired=0.
REQ-027 Reset SHALL override every other event, including an active grant (mid-grant reset aborts immediately without an expired pulse).
REQ-028 The first arbitration after reset SHALL search from index 0.

Verification
REQ-029 Reset, then req=8'h01 -> next cycle grant=8'h01, grant_idx=0, grant_valid=1.
REQ-030 req=8'hFF held, done pulsed on each grant's 2nd cycle -> grant_idx sequence 0,1,2,...,7,0, with one IDLE cycle between grants.
REQ-031 After grant to 4 released (ptr=5), req=8'b0000_1001 -> grant_idx=0 (wrap-around), grant=8'h01.
REQ-032 MAX_HOLD=15, req=8'h06 held, done=0 -> grant_idx=1 for exactly 15 cycles, then IDLE cycle with expired=1, then grant_idx=2.
REQ-033 done=1 in the 15th grant cycle -> release with expired=0; grantee drops req mid-grant -> release next edge, expired=0.
REQ-034 rst=1 in the 3rd cycle of grant to 6 -> next cycle all outputs zero; req=8'hC0 afterwards -> grant_idx=6.

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8 request/grant bundle.
// master drives requests, slave is the arbiter.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       expired;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  expired
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output expired
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold timeout.
// One idle cycle always separates two grants.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter8_if.slave bus
);

  localparam logic [3:0] HMAX = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [3:0]  hold;
  logic [2:0]  gidx;
  logic [7:0]  grant_q;
  logic        valid_q;
  logic        exp_q;

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  off;
  logic [2:0]  win;
  logic [7:0]  win_oh;
  logic        own;
  logic        tmo;
  logic        rel;

  // Rotate so the pointer sits at bit 0, then
  // pick the lowest set bit.
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    win    = ptr + off;
    win_oh = 8'(1) << win;
  end

  always_comb begin
    own = bus.req[gidx];
    tmo = (hold == HMAX);
    rel = bus.done | ~own | tmo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      hold    <= '0;
      gidx    <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          exp_q <= 1'b0;
          if (|bus.req) begin
            state   <= GRANT;
            gidx    <= win;
            grant_q <= win_oh;
            valid_q <= 1'b1;
            hold    <= 4'd1;
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= IDLE;
            ptr     <= gidx + 3'd1;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold    <= '0;
            // timeout only counts when nothing else
            // would have ended the grant anyway
            exp_q   <= tmo & ~bus.done & own;
          end else begin
            hold <= hold + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = gidx;
  assign bus.grant_valid = valid_q;
  assign bus.expired     = exp_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// rr_arbiter8 bench: directed scenarios plus random
// traffic, checked against a queue-fed reference.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 15;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       e;
  } exp_t;

  logic clk;
  logic rst;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference state
  int m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  int m_exp  = 0;

  function automatic int first(int p, logic [7:0] q);
    for (int k = 0; k < 8; k++)
      if (q[(p + k) % 8]) return (p + k) % 8;
    return p;
  endfunction

  task automatic step(input logic r,
                      input logic [7:0] q,
                      input logic d);
    exp_t e;
    logic keep;
    @(negedge clk);
    rst      = r;
    bus.req  = q;
    bus.done = d;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_idx = 0;
      m_exp = 0; m_held = 0;
    end else if (m_busy == 0) begin
      m_exp = 0;
      if (q != 8'h00) begin
        m_idx  = first(m_ptr, q);
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      keep = q[m_idx];
      if (d || !keep || m_held == MAX_HOLD) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        m_exp  = (!d && keep) ? 1 : 0;
      end else begin
        m_held++;
      end
    end
    e.v = (m_busy != 0);
    e.i = 3'(m_idx);
    e.g = (m_busy != 0) ? (8'(1) << m_idx) : 8'h00;
    e.e = (m_exp != 0);
    sb.push_back(e);
  endtask

  // monitor: one expected bundle per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.grant !== e.g || bus.grant_idx !== e.i ||
            bus.grant_valid !== e.v || bus.expired !== e.e) begin
          errors++;
          $display("FAIL out t=%0t got g=%h i=%0d v=%b e=%b want g=%h i=%0d v=%b e=%b",
                   $time, bus.grant, bus.grant_idx,
                   bus.grant_valid, bus.expired,
                   e.g, e.i, e.v, e.e);
        end
      end
    end
  end

  task automatic rr_pulse(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 8'hFF, (m_busy != 0 && m_held == 2));
  endtask

  initial begin
    logic [7:0] r;
    int         guard;
    rst = 1'b1;
    bus.req = '0;
    bus.done = 1'b0;

    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // single requester, then drop
    repeat (3) step(1'b0, 8'h01, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // full rotation 0..7,0
    step(1'b1, 8'h00, 1'b0);
    rr_pulse(28);

    // wrap after grant to 4
    step(1'b1, 8'h00, 1'b0);
    guard = 0;
    while (!(m_busy == 0 && m_ptr == 5) && guard < 100) begin
      rr_pulse(1);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL wrap_setup got guard=%0d want <100", guard);
    end
    repeat (3) step(1'b0, 8'h09, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // timeout on 1, then 2
    step(1'b1, 8'h00, 1'b0);
    repeat (40) step(1'b0, 8'h06, 1'b0);

    // done coincides with the last allowed cycle
    step(1'b1, 8'h00, 1'b0);
    repeat (20)
      step(1'b0, 8'h06, (m_busy != 0 && m_held == MAX_HOLD));

    // grantee drops request mid-grant
    step(1'b1, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h08, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // reset in 3rd grant cycle
    step(1'b1, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h40, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    repeat (3) step(1'b0, 8'hC0, 1'b0);

    // done in IDLE is ignored
    step(1'b1, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // random traffic; req mostly stable so timeouts occur
    r = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      step(($urandom_range(0, 199) == 0),
           r,
           ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got left=%0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
